// File: rtl/bpb_update_queue.sv
// In-flight branch tracker: queues predictions from fetch and emits registered
// predictor training beats as execute resolves branches. Optional BPB_UPDATE_STATS_EN adds counters.
`ifndef BPB_T
`define BPB_T 10
`endif

module bpb_update_queue #(
    parameter int INDEX_WIDTH = `BPB_T,
    parameter int DEPTH_WIDTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [INDEX_WIDTH-1:0] push_index_i,
    input  logic [1:0]             push_taken_i,
    output logic                   full_o,
    output logic [DEPTH_WIDTH:0]   count_o,
    input  logic                   resolve_i,
    input  logic                   resolve_taken_i,
    input  logic                   flush_i,
    output logic                   update_en_o,
    output logic [INDEX_WIDTH-1:0] update_index_o,
    output logic                   update_taken_o,
    output logic                   mispredict_o
`ifdef BPB_UPDATE_STATS_EN
    ,
    output logic [31:0]            resolve_cnt_o,
    output logic [31:0]            mispredict_cnt_o
`endif
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] DEPTH_C = {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [DEPTH_WIDTH:0] LAST_C  = {1'b0, {DEPTH_WIDTH{1'b1}}};
    localparam logic [DEPTH_WIDTH:0] ONE_C   = {{DEPTH_WIDTH{1'b0}}, 1'b1};

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [INDEX_WIDTH-1:0] mem_index_q [DEPTH];
    logic                   mem_dir_q   [DEPTH];

    logic [DEPTH_WIDTH:0]   head_q, head_d;
    logic [DEPTH_WIDTH:0]   tail_q, tail_d;
    logic [DEPTH_WIDTH:0]   count_q, count_d;
    logic                   upd_en_q, upd_en_d;
    logic [INDEX_WIDTH-1:0] upd_index_q, upd_index_d;
    logic                   upd_taken_q, upd_taken_d;
    logic                   mispredict_q, mispredict_d;

    logic [1:0]             occ_state;
    logic                   resolve_acc;
    logic                   push_acc;

    // Only the predicted direction (counter MSB) matters when training.
    logic                   unused_taken_lsb;
    assign unused_taken_lsb = push_taken_i[0];

    function automatic logic [DEPTH_WIDTH:0] ptr_inc(input logic [DEPTH_WIDTH:0] p);
        ptr_inc = (p == LAST_C) ? '0 : p + ONE_C;
    endfunction

    always_comb begin
        occ_state = ST_PARTIAL;
        if (count_q == '0) begin
            occ_state = ST_EMPTY;
        end else if (count_q == DEPTH_C) begin
            occ_state = ST_FULL;
        end
    end

    always_comb begin
        resolve_acc  = resolve_i && (occ_state != ST_EMPTY);
        push_acc     = push_i && !flush_i && ((occ_state != ST_FULL) || resolve_acc);

        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        upd_en_d     = resolve_acc;
        upd_index_d  = upd_index_q;
        upd_taken_d  = upd_taken_q;
        mispredict_d = mispredict_q;

        // A flush still lets the same-cycle resolve produce its beat.
        if (resolve_acc) begin
            upd_index_d  = mem_index_q[head_q[DEPTH_WIDTH-1:0]];
            upd_taken_d  = resolve_taken_i;
            mispredict_d = mem_dir_q[head_q[DEPTH_WIDTH-1:0]] ^ resolve_taken_i;
        end

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (resolve_acc) head_d = ptr_inc(head_q);
            if (push_acc)    tail_d = ptr_inc(tail_q);
            if (push_acc && !resolve_acc) begin
                count_d = count_q + ONE_C;
            end else if (!push_acc && resolve_acc) begin
                count_d = count_q - ONE_C;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem_index_q[tail_q[DEPTH_WIDTH-1:0]] <= push_index_i;
            mem_dir_q[tail_q[DEPTH_WIDTH-1:0]]   <= push_taken_i[1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            upd_en_q     <= 1'b0;
            upd_index_q  <= '0;
            upd_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            upd_en_q     <= upd_en_d;
            upd_index_q  <= upd_index_d;
            upd_taken_q  <= upd_taken_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign full_o         = (occ_state == ST_FULL);
    assign count_o        = count_q;
    assign update_en_o    = upd_en_q;
    assign update_index_o = upd_index_q;
    assign update_taken_o = upd_taken_q;
    assign mispredict_o   = mispredict_q;

`ifdef BPB_UPDATE_STATS_EN
    logic [31:0] resolve_cnt_q, resolve_cnt_d;
    logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

    // Counters advance on the same edge the beat appears; flush leaves them alone.
    always_comb begin
        resolve_cnt_d    = resolve_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (resolve_acc) begin
            resolve_cnt_d = resolve_cnt_q + 32'd1;
            if (mispredict_d) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resolve_cnt_q    <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            resolve_cnt_q    <= resolve_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign resolve_cnt_o    = resolve_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
`else
    // Statistics counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_bpb_update_queue.sv
// Scoreboard bench for bpb_update_queue: a queue-based reference model predicts
// every update beat, and a separate monitor compares beats as the DUT emits them.
module tb_bpb_update_queue;

    localparam int IW    = 8;
    localparam int DW    = 2;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          push_i;
    logic [IW-1:0] push_index_i;
    logic [1:0]    push_taken_i;
    logic          full_o;
    logic [DW:0]   count_o;
    logic          resolve_i;
    logic          resolve_taken_i;
    logic          flush_i;
    logic          update_en_o;
    logic [IW-1:0] update_index_o;
    logic          update_taken_o;
    logic          mispredict_o;
`ifdef BPB_UPDATE_STATS_EN
    logic [31:0]   resolve_cnt_o;
    logic [31:0]   mispredict_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    bpb_update_queue #(.INDEX_WIDTH(IW), .DEPTH_WIDTH(DW)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .push_i          (push_i),
        .push_index_i    (push_index_i),
        .push_taken_i    (push_taken_i),
        .full_o          (full_o),
        .count_o         (count_o),
        .resolve_i       (resolve_i),
        .resolve_taken_i (resolve_taken_i),
        .flush_i         (flush_i),
        .update_en_o     (update_en_o),
        .update_index_o  (update_index_o),
        .update_taken_o  (update_taken_o),
        .mispredict_o    (mispredict_o)
`ifdef BPB_UPDATE_STATS_EN
        ,
        .resolve_cnt_o   (resolve_cnt_o),
        .mispredict_cnt_o(mispredict_cnt_o)
`endif
    );

    typedef struct packed {logic [IW-1:0] idx; logic [1:0] tk;} ent_t;
    typedef struct packed {logic [IW-1:0] idx; logic tk; logic misp;} beat_t;

    ent_t        model_q[$];
    beat_t       exp_q[$];
    logic [31:0] m_res = '0;
    logic [31:0] m_mis = '0;
    int          errors = 0;
    int          checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs after checking the state left by the previous edge,
    // and advances the reference model by that cycle's rules.
    task automatic applyStimulus(input logic p, input logic [IW-1:0] pi, input logic [1:0] pt,
                                 input logic r, input logic rt, input logic f);
        bit   racc;
        bit   pacc;
        ent_t e;
        @(posedge clk_i);
        #2;
        checkOutput("count", 32'(count_o), 32'(model_q.size()));
        checkOutput("full", 32'(full_o), 32'(model_q.size() == DEPTH));
`ifdef BPB_UPDATE_STATS_EN
        checkOutput("resolve_cnt", resolve_cnt_o, m_res);
        checkOutput("mispredict_cnt", mispredict_cnt_o, m_mis);
`endif
        push_i          = p;
        push_index_i    = pi;
        push_taken_i    = pt;
        resolve_i       = r;
        resolve_taken_i = rt;
        flush_i         = f;
        racc = r && (model_q.size() > 0);
        pacc = p && !f && ((model_q.size() < DEPTH) || racc);
        if (racc) begin
            e = model_q.pop_front();
            exp_q.push_back('{e.idx, rt, e.tk[1] ^ rt});
            m_res = m_res + 32'd1;
            if (e.tk[1] != rt) m_mis = m_mis + 32'd1;
        end
        if (f) model_q.delete();
        else if (pacc) model_q.push_back('{pi, pt});
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_count"}, 32'(count_o), 32'd0);
        checkOutput({tag, "_full"}, 32'(full_o), 32'd0);
        checkOutput({tag, "_update_en"}, 32'(update_en_o), 32'd0);
        checkOutput({tag, "_update_index"}, 32'(update_index_o), 32'd0);
        checkOutput({tag, "_update_taken"}, 32'(update_taken_o), 32'd0);
        checkOutput({tag, "_mispredict"}, 32'(mispredict_o), 32'd0);
`ifdef BPB_UPDATE_STATS_EN
        checkOutput({tag, "_resolve_cnt"}, resolve_cnt_o, 32'd0);
        checkOutput({tag, "_mispredict_cnt"}, mispredict_cnt_o, 32'd0);
`endif
    endtask

    initial begin : monitor
        beat_t b;
        forever begin
            @(negedge clk_i);
            if (rst_ni && update_en_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got index %0d expected no beat at %0t",
                             update_index_o, $time);
                end else begin
                    b = exp_q.pop_front();
                    checkOutput("update_index", 32'(update_index_o), 32'(b.idx));
                    checkOutput("update_taken", 32'(update_taken_o), 32'(b.tk));
                    checkOutput("mispredict", 32'(mispredict_o), 32'(b.misp));
                end
            end
        end
    end

    initial begin
        push_i = 0; push_index_i = '0; push_taken_i = '0;
        resolve_i = 0; resolve_taken_i = 0; flush_i = 0;
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        #2 checkResetOutputs("reset");
        @(posedge clk_i);
        #2 rst_ni = 1'b1;

        // Single mispredicted branch.
        applyStimulus(1, 8'd5, 2'b11, 0, 0, 0);
        applyStimulus(0, 8'd0, 2'b00, 1, 0, 0);
        applyStimulus(0, 8'd0, 2'b00, 0, 0, 0);

        // Fill, drop a push on full, then drain in order.
        for (int i = 1; i <= 4; i++) applyStimulus(1, 8'(i), 2'(i), 0, 0, 0);
        applyStimulus(1, 8'd9, 2'b10, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'd0, 2'b00, 1, 1'(i), 0);

        // Push and resolve together while full; idx 7 drains last.
        for (int i = 11; i <= 14; i++) applyStimulus(1, 8'(i), 2'b10, 0, 0, 0);
        applyStimulus(1, 8'd7, 2'b01, 1, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 8'd0, 2'b00, 1, 0, 0);

        // Flush together with resolve and push.
        applyStimulus(1, 8'd21, 2'b11, 0, 0, 0);
        applyStimulus(1, 8'd22, 2'b00, 0, 0, 0);
        applyStimulus(1, 8'd23, 2'b11, 1, 1, 1);
        applyStimulus(0, 8'd0, 2'b00, 1, 1, 0);

        // Resolve on empty with a push, then reset mid-stream with a beat pending.
        applyStimulus(1, 8'd30, 2'b10, 1, 0, 0);
        applyStimulus(1, 8'd33, 2'b00, 1, 1, 0);
        @(posedge clk_i);
        #2;
        checkOutput("beat_before_reset", 32'(update_en_o), 32'd1);
        rst_ni = 1'b0;
        #1 checkResetOutputs("async_reset");
        model_q.delete();
        exp_q.delete();
        m_res = '0;
        m_mis = '0;
        push_i = 0; resolve_i = 0; flush_i = 0;
        @(posedge clk_i);
        #2 rst_ni = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 99) < 60, 8'($urandom), 2'($urandom),
                          $urandom_range(0, 99) < 55, 1'($urandom), $urandom_range(0, 99) < 4);
        end

        // Flush must leave statistics untouched.
        applyStimulus(1, 8'd1, 2'b11, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'd0, 2'b00, 0, 0, 0);
        @(negedge clk_i);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
